// File: rtl/weight_bram_writer.sv
// Packs a 32-bit valid/ready word stream into 5*MAC_NUM-bit weight lines and
// writes each completed line to consecutive BRAM addresses from a programmable base.
module weight_bram_writer #(
  parameter int MAC_NUM            = 256,
  parameter int BRAM_ADDRESS_WIDTH = 12
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [BRAM_ADDRESS_WIDTH-1:0]   base_addr,
  input  logic [BRAM_ADDRESS_WIDTH:0]     line_count,
  input  logic [31:0]                     s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic [BRAM_ADDRESS_WIDTH-1:0]   bram_address_W,
  output logic [5*MAC_NUM-1:0]            weight_to_bram,
  output logic                            bram_en,
  output logic                            bram_we,
  output logic                            busy,
  output logic                            done
);

  localparam int LINE_W = 5 * MAC_NUM;
  localparam int WPL    = (LINE_W + 31) / 32;
  localparam int CNT_W  = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int AW     = BRAM_ADDRESS_WIDTH;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  word_cnt_reg;
  logic [AW:0]       lines_left_reg;
  logic [AW-1:0]     addr_reg;
  logic [LINE_W-1:0] line_buf;
  logic              accept;
  logic              last_word;

  // s_ready depends only on state, so accept has no path back into s_ready.
  assign accept    = (state_reg == FILL) && s_valid;
  assign last_word = accept && (word_cnt_reg == CNT_W'(WPL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    s_ready    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    bram_en    = 1'b0;
    bram_we    = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = (line_count != '0) ? FILL : DONE;
      end
      FILL: begin
        s_ready = 1'b1;
        if (last_word) state_next = WRITE;
      end
      WRITE: begin
        bram_en    = 1'b1;
        bram_we    = 1'b1;
        state_next = (lines_left_reg == {{AW{1'b0}}, 1'b1}) ? DONE : FILL;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt_reg   <= '0;
      lines_left_reg <= '0;
      addr_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && (line_count != '0)) begin
            addr_reg       <= base_addr;
            lines_left_reg <= line_count;
            word_cnt_reg   <= '0;
          end
        end
        FILL: begin
          if (last_word)   word_cnt_reg <= '0;
          else if (accept) word_cnt_reg <= word_cnt_reg + 1'b1;
        end
        WRITE: begin
          lines_left_reg <= lines_left_reg - 1'b1;
          addr_reg       <= addr_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // One register per word slot; the final slot keeps only the bits that fit in the line.
  genvar gi;
  generate
    for (gi = 0; gi < WPL; gi++) begin : g_slot
      localparam int LO = 32 * gi;
      localparam int SW = ((LINE_W - LO) < 32) ? (LINE_W - LO) : 32;
      logic [SW-1:0] slot_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          slot_reg <= '0;
        else if (accept && (word_cnt_reg == CNT_W'(gi)))
          slot_reg <= s_data[SW-1:0];
      end

      assign line_buf[LO +: SW] = slot_reg;
    end
  endgenerate

  assign weight_to_bram = line_buf;
  assign bram_address_W = addr_reg;

endmodule
